lcd_frame_scanner: RTL and testbench
====================================

LCD_FRAME_SCANNER -- requirements
Module: lcd_frame_scanner

Interface
REQ-001 SHALL have parameter REFRESH_GAP, default 50000, idle clock cycles between frames (1 ms at 50 MHz), legal range >= 1.
REQ-002 SHALL have port clock_50mhz  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port wr_en  input  1  write one character cell this cycle.
REQ-005 SHALL have port wr_row  input  1  target row (0 = top, 1 = bottom).
REQ-006 SHALL have port wr_col  input  4  target column 0..15.
REQ-007 SHALL have port wr_char  input  8  ASCII code to store.
REQ-008 SHALL have port clr  input  1  single-cycle request to fill the buffer with 0x20.
REQ-009 SHALL have port busy  output  1  high while a clear is in progress.
REQ-010 SHALL have port out_valid  output  1  LCD transaction offered to the downstream pin driver.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the transaction this cycle.
REQ-012 SHALL have port out_rs  output  1  0 = command byte, 1 = character byte.
REQ-013 SHALL have port out_data  output  8  LCD byte.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last cell of row 1 is accepted.

Function
REQ-015 SHALL hold a 32-entry x 8-bit character buffer, where index = wr_row*16 + wr_col.
REQ-016 SHALL commit a write (wr_en=1, busy=0) at the clock edge; when busy=1, wr_en SHALL be ignored.
REQ-017 SHALL run the scanner in states GAP, ADDR and CHAR, with row and column counters.
REQ-018 GAP: out_valid=0; an internal counter runs 0..REFRESH_GAP-1; on the terminal count, next state = ADDR with row=0.
REQ-019 ADDR: out_valid=1, out_rs=0, out_data = 0x80 for row 0 or 0xC0 for row 1; on handshake, next state = CHAR with col=0.
REQ-020 CHAR: out_valid=1, out_rs=1, out_data = buffer[row*16+col]; on handshake with col<15, col increments and the state stays CHAR.
REQ-021 CHAR handshake at col=15: row 0 goes to ADDR with row=1; row 1 goes to GAP with counter=0 and frame_done=1 for exactly the next cycle.
REQ-022 A handshake SHALL be the cycle with out_valid=1 and out_ready=1; a full frame is 34 transactions (2 address bytes + 32 characters).
REQ-023 out_rs and out_data SHALL be registered, loaded on the same edge that enters or advances ADDR/CHAR.
REQ-024 out_rs and out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 A buffer write to the cell being loaded on the same edge SHALL NOT affect the loaded value (read-before-write); the new value appears on the next frame.
REQ-026 clr with busy=0 SHALL set busy=1 on the next cycle and write 0x20 to cells 0..31, one per cycle, ascending.
REQ-027 busy SHALL drop after the cycle that writes cell 31 (32 cycles high).
REQ-028 clr while busy=1 SHALL be ignored; clr and wr_en in the same cycle with busy=0: clr wins and the write is discarded.
REQ-029 The scanner SHALL continue during a clear and emit whatever the buffer holds at each load.
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 reset_n=0 SHALL immediately force out_valid=0, out_rs=0, out_data=0x00, frame_done=0, busy=0, state=GAP, gap counter=0, row=0, col=0.
REQ-032 All 32 buffer cells SHALL read 0x20 after reset release.
REQ-033 Reset asserted mid-transaction (out_valid=1, out_ready=0) SHALL abandon the transaction with no handshake counted.
REQ-034 After reset release, the first out_valid SHALL rise exactly REFRESH_GAP cycles later.

Verification
REQ-035 Reset release, REFRESH_GAP=4, out_ready=1 -> out_valid rises at cycle 4; stream is 0x80 (rs=0), 16x 0x20 (rs=1), 0xC0 (rs=0), 16x 0x20; frame_done pulses once; repeats after a 4-cycle gap.
REQ-036 Write row0/col0=0x2A and row1/col15=0x54, wait one frame -> next frame byte 2 = 0x2A and byte 34 = 0x54, all others 0x20.
REQ-037 out_ready held 0 for 10 cycles during CHAR col=5 while wr_char=0x41 targets that cell -> out_data constant for all 10 cycles; 0x41 shown on the next frame.
REQ-038 clr pulse, then wr_en on cycles 1..32 after it -> busy high exactly 32 cycles, writes dropped, buffer all 0x20; a second clr at cycle 10 has no effect.
REQ-039 Random out_ready (50%) over 5 frames -> every frame is exactly 34 handshakes in the order of REQ-019..REQ-021, and out_data is never changed while stalled.
REQ-040 reset_n pulsed low at CHAR row1/col7 with out_ready=0 -> out_valid=0 asynchronously; after release, the restart is a full frame from 0x80.

Source files
------------

// File: rtl/lcd_frame_scanner.sv
// Two-row, 16-column character LCD refresher: a 32-cell character buffer with a
// bulk clear, scanned out as a valid/ready stream of address and character bytes.
module lcd_frame_scanner #(
  parameter int unsigned REFRESH_GAP = 50000
) (
  input  logic       clock_50mhz,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clr,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_rs,
  output logic [7:0] out_data,
  output logic       frame_done
);

  localparam int unsigned CELLS = 32;
  localparam int unsigned GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);
  localparam logic [7:0] BLANK     = 8'h20;
  localparam logic [7:0] ROW0_ADDR = 8'h80;
  localparam logic [7:0] ROW1_ADDR = 8'hC0;

  typedef enum logic [1:0] {S_GAP, S_ADDR, S_CHAR} state_t;

  logic [7:0]       buffer [CELLS];
  logic [4:0]       clr_idx;
  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             row;
  logic [3:0]       col;
  logic [3:0]       col_inc;

  assign col_inc = col + 4'd1;

  // Character store; an active clear owns the write port, so user writes are dropped.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CELLS; i++) buffer[i] <= BLANK;
    end else if (busy) begin
      buffer[clr_idx] <= BLANK;
    end else if (wr_en && !clr) begin
      buffer[{wr_row, wr_col}] <= wr_char;
    end
  end

  // Clear sequencer: one cell per cycle, 32 cycles, retriggers ignored while busy.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      clr_idx <= 5'd0;
    end else if (busy) begin
      clr_idx <= clr_idx + 5'd1;
      if (clr_idx == 5'd31) busy <= 1'b0;
    end else if (clr) begin
      busy    <= 1'b1;
      clr_idx <= 5'd0;
    end
  end

  // Scanner: buffer reads sample the pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_GAP;
      gap_cnt    <= '0;
      row        <= 1'b0;
      col        <= 4'd0;
      out_valid  <= 1'b0;
      out_rs     <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= S_ADDR;
            gap_cnt   <= '0;
            row       <= 1'b0;
            col       <= 4'd0;
            out_valid <= 1'b1;
            out_rs    <= 1'b0;
            out_data  <= ROW0_ADDR;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_ADDR: begin
          if (out_ready) begin
            state    <= S_CHAR;
            col      <= 4'd0;
            out_rs   <= 1'b1;
            out_data <= buffer[{row, 4'd0}];
          end
        end
        S_CHAR: begin
          if (out_ready) begin
            if (col != 4'd15) begin
              col      <= col_inc;
              out_data <= buffer[{row, col_inc}];
            end else if (!row) begin
              state    <= S_ADDR;
              row      <= 1'b1;
              out_rs   <= 1'b0;
              out_data <= ROW1_ADDR;
            end else begin
              state      <= S_GAP;
              gap_cnt    <= '0;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_GAP;
          gap_cnt   <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Directed bench for lcd_frame_scanner: per-cycle vector table for the first frame,
// then hand-written sequences for writes, stalls, clear, random backpressure and reset.
module tb_lcd_frame_scanner;

  localparam int unsigned GAP = 4;

  typedef struct {
    logic       rdy;
    logic       ev;
    logic       ers;
    logic [7:0] edata;
    logic       efd;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;
  logic       frame_done;

  int n_cmp;
  int n_fail;
  logic [7:0] model [32];
  vec_t vecs [42];

  lcd_frame_scanner #(.REFRESH_GAP(GAP)) dut (
    .clock_50mhz(clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .clr        (clr),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs     (out_rs),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] view();
    return 16'({busy, out_valid, frame_done, out_valid & out_rs,
                out_valid ? out_data : 8'h00});
  endfunction

  function automatic logic [8:0] exp_byte(input int t);
    if (t == 0)  return {1'b0, 8'h80};
    if (t <= 16) return {1'b1, model[t-1]};
    if (t == 17) return {1'b0, 8'hC0};
    return {1'b1, model[t-2]};
  endfunction

  // Expects the row-0 address byte to be on offer; consumes one whole frame.
  task automatic collect_frame(input bit rnd);
    logic [8:0] e;
    bit acc;
    int waits;
    for (int t = 0; t < 34; t++) begin
      e = exp_byte(t);
      check($sformatf("frame_byte%0d", t), 16'({out_valid, out_rs, out_data}), 16'({1'b1, e}));
      waits = 0;
      acc = 1'b0;
      while (!acc && waits < 200) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = out_ready;
        step();
        waits++;
        if (!acc)
          check($sformatf("stall_hold%0d", t), 16'({out_valid, out_rs, out_data}), 16'({1'b1, e}));
      end
      if (!acc) timeout("handshake");
    end
    out_ready = 1'b1;
    check("frame_done_pulse", 16'({frame_done, out_valid}), 16'(2'b10));
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) timeout("frame_start");
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    out_ready = 1'b1;
    do begin
      step();
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) timeout("frame_done_wait");
  endtask

  task automatic write_cell(input logic [4:0] idx, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_row  = idx[4];
    wr_col  = idx[3:0];
    wr_char = ch;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_row    = 1'b0;
    wr_col    = 4'd0;
    wr_char   = 8'h00;
    clr       = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;

    // First frame after reset, one entry per clock edge
    for (int i = 0; i < 42; i++) begin
      automatic int e = i + 1;
      vecs[i] = '{rdy: 1'b1, ev: 1'b0, ers: 1'b0, edata: 8'h00, efd: 1'b0};
      if (e == 4 || e == 42) begin
        vecs[i].ev = 1'b1; vecs[i].edata = 8'h80;
      end else if ((e >= 5 && e <= 20) || (e >= 22 && e <= 37)) begin
        vecs[i].ev = 1'b1; vecs[i].ers = 1'b1; vecs[i].edata = 8'h20;
      end else if (e == 21) begin
        vecs[i].ev = 1'b1; vecs[i].edata = 8'hC0;
      end else if (e == 38) begin
        vecs[i].efd = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'({out_valid, out_rs, out_data, frame_done, busy}), 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < 42; i++) begin
      out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), view(),
            16'({1'b0, vecs[i].ev, vecs[i].efd, vecs[i].ev & vecs[i].ers,
                 vecs[i].ev ? vecs[i].edata : 8'h00}));
    end

    // Writes to the two corner cells while the row-0 address byte is stalled
    out_ready = 1'b0;
    write_cell(5'd0, 8'h2A);
    step();
    write_cell(5'd31, 8'h54);
    step();
    wr_en = 1'b0;
    model[0]  = 8'h2A;
    model[31] = 8'h54;
    collect_frame(1'b0);
    wait_frame_start();
    collect_frame(1'b0);

    // Stall at row 0 / col 5 while that cell is rewritten; then a same-edge write to col 6
    wait_frame_start();
    out_ready = 1'b1;
    repeat (6) step();
    check("stall_entry", 16'({out_valid, out_rs, out_data}), 16'({2'b11, model[5]}));
    out_ready = 1'b0;
    write_cell(5'd5, 8'h41);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("stall_write%0d", k), 16'({out_valid, out_rs, out_data}), 16'({2'b11, model[5]}));
    end
    out_ready = 1'b1;
    write_cell(5'd6, 8'h42);
    step();
    wr_en = 1'b0;
    check("read_before_write", 16'({out_valid, out_rs, out_data}), 16'({2'b11, model[6]}));
    wait_frame_done();
    model[5] = 8'h41;
    model[6] = 8'h42;
    wait_frame_start();
    collect_frame(1'b0);

    // Clear: simultaneous write is discarded, writes and a second clr while busy are dropped
    out_ready = 1'b1;
    clr = 1'b1;
    write_cell(5'd3, 8'h99);
    step();
    clr = 1'b0;
    check("busy_rise", 16'(busy), 16'(1));
    for (int k = 1; k <= 33; k++) begin
      wr_en = 1'b0;
      if (k <= 32) write_cell(5'(k + 30), 8'(8'h60 + k));
      clr = (k == 10);
      step();
      check($sformatf("busy_k%0d", k), 16'(busy), 16'(k <= 31 ? 1 : 0));
    end
    wr_en = 1'b0;
    clr   = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    wait_frame_done();
    wait_frame_start();
    collect_frame(1'b0);

    // Distinct contents, then five frames under random backpressure
    for (int i = 0; i < 32; i++) begin
      write_cell(5'(i), 8'(8'h40 + i));
      model[i] = 8'(8'h40 + i);
      step();
    end
    wr_en = 1'b0;
    wait_frame_done();
    for (int f = 0; f < 5; f++) begin
      wait_frame_start();
      collect_frame(1'b1);
    end

    // Reset asserted mid-transaction at row 1 / col 7
    wait_frame_start();
    repeat (17) step();
    check("row1_addr", 16'({out_valid, out_rs, out_data}), 16'({2'b10, 8'hC0}));
    repeat (8) step();
    check("row1_col7", 16'({out_valid, out_rs, out_data}), 16'({2'b11, model[23]}));
    out_ready = 1'b0;
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 16'({out_valid, out_rs, out_data, frame_done, busy}), 16'h0000);
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("restart_gap%0d", k), 16'(out_valid), 16'(0));
    end
    step();
    check("restart_addr", 16'({out_valid, out_rs, out_data}), 16'({2'b10, 8'h80}));
    collect_frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
